instr_encoder: RTL
==================

# instr_encoder

Sequential instruction encoder and program writer for the 32-bit micro CPU. It accepts decoded instruction fields over a valid/ready stream, packs each into the 32-bit word format that the control unit decodes, and writes the words to consecutive instruction-memory addresses over a valid/ready write port. It sits between the program-load path (test harness or boot loader) and instruction memory, and flags illegal opcodes and address-space overflow.

## Interface
- ADDR_W, 8, instruction-memory address width; depth is 2^ADDR_W words.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session. Ignored unless the block is in IDLE.
- start_addr  in  ADDR_W  first write address, sampled on start.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  encoder can accept a tuple.
- in_op  in  6  opcode.
- in_ra  in  5  register field A, placed at [25:21].
- in_rb  in  5  register field B, placed at [20:16].
- in_rc  in  5  register field C, placed at [15:11].
- in_imm  in  26  immediate or jump target.
- in_last  in  1  marks the final tuple of the session.
- wr_valid  out  1  write request.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  32  encoded instruction.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at session end.
- err_illegal  out  1  sticky; an illegal opcode was dropped this session.
- err_full  out  1  sticky; the session hit the top address without in_last.
- words_written  out  ADDR_W+1  count of words written this session.

## Operation
- Encoding. [31:26] is always in_op. All bits not listed below are forced to 0, whatever the inputs.
  - NOP (0x00): all zero.
  - ADD/SUB/MUL/AND/OR (0x01–0x05): ra, rb, rc.
  - JMP (0x06), JEQ (0x0B): [25:0] = in_imm.
  - LUI (0x07), LLI (0x08): ra; [15:0] = in_imm[15:0].
  - CMP (0x0A): ra, rb.
  - LOD (0x0C): ra is the destination and rb is the address register.
  - STR (0x0D): ra is the data register and rb is the address register.
  - Illegal: 0x09 and 0x0E–0x3F.
- FSM states: IDLE, LOAD, HOLD, DONE.
  - IDLE: in_ready = 0. On start:
    - wr_addr is loaded from start_addr.
    - words_written, err_illegal and err_full clear.
    - Go to LOAD.
  - LOAD: in_ready = 1. On handshake (in_valid & in_ready):
    - Legal opcode: register the encoded word into wr_data, latch in_last, assert wr_valid, go to HOLD.
    - Illegal opcode: drop the word and set err_illegal. wr_addr does not change. Go to DONE if in_last is set, otherwise stay in LOAD.
  - HOLD: in_ready = 0 and wr_valid = 1. wr_addr and wr_data stay stable until wr_ready. On wr_ready:
    - wr_valid drops and words_written increments.
    - If the latched last is set, go to DONE.
    - Else, if wr_addr = 2^ADDR_W−1, set err_full and go to DONE. wr_addr stays at that value and does not wrap.
    - Else, increment wr_addr and go to LOAD.
  - DONE: done = 1 for one cycle, then go to IDLE. err_* and words_written hold their values until the next start.
- A start pulse outside IDLE has no effect.

## Timing
- Reset values: state IDLE. in_ready, wr_valid, busy, done, err_illegal and err_full are 0. wr_addr, wr_data and words_written are 0.
- Reset mid-session returns the block to IDLE on the next edge. Any pending write is abandoned and wr_valid is 0 after that edge.
- in_ready and wr_valid come from registered state only; there is no combinational path from in_valid or wr_ready.
- Latency: wr_valid rises on the edge after the input handshake.
- Throughput: with wr_ready held high, one word every 2 cycles.
- done asserts on the cycle after the final wr_ready handshake, or after the illegal-last handshake.
- words_written and wr_addr update on the wr_ready edge.

## Test plan
- ADD with ra=1, rb=2, rc=3, start_addr=0x10, in_last=1 -> wr_data=0x04221800 at wr_addr 0x10; done one cycle later; words_written=1.
- LUI with ra=5, in_imm=0x3FFBEEF, plus a stray rc=7 -> wr_data=0x1CA0BEEF; the upper immediate bits and rc are ignored.
- JEQ with in_imm=0x0000123, then STR with ra=4, rb=9 and in_last=1:
  - JEQ -> wr_data=0x2C000123 at address A.
  - STR -> wr_data=0x34890000 at address A+1.
- Sequence ADD, opcode 0x09, then OR (last) -> two writes at consecutive addresses; err_illegal=1; words_written=2.
- wr_ready held low for 5 cycles in HOLD -> wr_valid, wr_addr and wr_data stay stable; in_ready=0. Assert rst during the stall -> IDLE with all outputs at reset values.
- ADDR_W=2, start_addr=2, three tuples without in_last -> writes at 2 and 3; err_full=1; done pulses; the third tuple is never accepted; words_written=2.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder and program writer: packs decoded fields into 32-bit words
// and streams them to consecutive instruction-memory addresses.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_ra,
  input  logic [4:0]        in_rb,
  input  logic [4:0]        in_rc,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
  localparam logic [ADDR_W:0]   WW_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [31:0]         r_wr_data;
  logic                r_last;
  logic [ADDR_W:0]     r_ww;
  logic                r_ill;
  logic                r_full;
  logic                w_legal;
  logic [31:0]         w_word;
  logic                w_hs;

  // Field packing; bits not owned by the opcode's format stay zero.
  always_comb begin
    w_word        = '0;
    w_word[31:26] = in_op;
    w_legal       = 1'b1;
    case (in_op)
      6'h00: ;
      6'h01, 6'h02, 6'h03, 6'h04, 6'h05: begin
        w_word[25:21] = in_ra;
        w_word[20:16] = in_rb;
        w_word[15:11] = in_rc;
      end
      6'h06, 6'h0B: w_word[25:0] = in_imm;
      6'h07, 6'h08: begin
        w_word[25:21] = in_ra;
        w_word[15:0]  = in_imm[15:0];
      end
      6'h0A, 6'h0C, 6'h0D: begin
        w_word[25:21] = in_ra;
        w_word[20:16] = in_rb;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_hs = in_valid && (r_state == S_LOAD);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_hs) begin
          if (w_legal)      w_next = S_HOLD;
          else if (in_last) w_next = S_DONE;
        end
      end
      S_HOLD: begin
        if (wr_ready) begin
          if (r_last || (r_wr_addr == TOP_ADDR)) w_next = S_DONE;
          else                                   w_next = S_LOAD;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_last    <= 1'b0;
      r_ww      <= '0;
      r_ill     <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wr_addr <= start_addr;
            r_ww      <= '0;
            r_ill     <= 1'b0;
            r_full    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            if (w_legal) begin
              r_wr_data <= w_word;
              r_last    <= in_last;
            end else begin
              r_ill <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Top address without last ends the session; the address never wraps.
          if (wr_ready) begin
            r_ww <= r_ww + WW_ONE;
            if (!r_last) begin
              if (r_wr_addr == TOP_ADDR) r_full    <= 1'b1;
              else                       r_wr_addr <= r_wr_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (r_state == S_LOAD);
  assign wr_valid      = (r_state == S_HOLD);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign err_illegal   = r_ill;
  assign err_full      = r_full;
  assign words_written = r_ww;

endmodule
